// File: rtl/md_sequencer.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign fix-up.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write HI/LO directly
// MUL   | 32 shift-add steps on operand magnitudes
// DIV   | 32 restoring shift-subtract steps on operand magnitudes
// FIX   | sign correction, HI/LO write, done pulse
module md_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] FUNC_MULT = 3'b001;
    localparam logic [2:0] FUNC_DIV  = 3'b010;
    localparam logic [2:0] FUNC_MTHI = 3'b011;
    localparam logic [2:0] FUNC_MTLO = 3'b100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] mag_a, mag_b;
    logic        sign_a, sign_b;
    logic        op_div;
    logic [31:0] work_hi, work_lo;

    logic        launch;
    logic        move_to;
    logic        neg_a, neg_b;
    logic [31:0] abs_a, abs_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    logic [63:0] prod, prod_fix;
    logic [31:0] raw_a;
    logic [31:0] fix_hi, fix_lo;

    assign launch  = start && !flush && (md_func == FUNC_MULT || md_func == FUNC_DIV);
    assign move_to = start && !flush && (md_func == FUNC_MTHI || md_func == FUNC_MTLO);

    assign neg_a = md_sign && src_a[31];
    assign neg_b = md_sign && src_b[31];
    assign abs_a = neg_a ? (32'd0 - src_a) : src_a;
    assign abs_b = neg_b ? (32'd0 - src_b) : src_b;

    // Product accumulates in work_hi while the multiplier shifts out of work_lo.
    assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_next = {mul_sum, work_lo[31:1]};

    // Remainder in work_hi, dividend shifts out of / quotient shifts into work_lo.
    assign div_shift = {work_hi, work_lo[31]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_ge    = !div_diff[32];
    assign div_next  = {div_ge ? div_diff[31:0] : div_shift[31:0], work_lo[30:0], div_ge};

    assign prod     = {work_hi, work_lo};
    assign prod_fix = (sign_a ^ sign_b) ? (64'd0 - prod) : prod;
    // Latched src_a rebuilt from magnitude; 32'h80000000 maps back onto itself.
    assign raw_a    = sign_a ? (32'd0 - mag_a) : mag_a;

    always_comb begin
        fix_hi = prod_fix[63:32];
        fix_lo = prod_fix[31:0];
        if (op_div) begin
            if (mag_b == 32'd0) begin
                fix_hi = raw_a;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = sign_a ? (32'd0 - work_hi) : work_hi;
                fix_lo = (sign_a ^ sign_b) ? (32'd0 - work_lo) : work_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = (md_func == FUNC_DIV) ? DIV : MUL;
            MUL, DIV: begin
                if (flush)             state_nxt = IDLE;
                else if (cnt == 5'd31) state_nxt = FIX;
            end
            FIX: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 5'd0;
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            op_div  <= 1'b0;
            work_hi <= 32'd0;
            work_lo <= 32'd0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        sign_a  <= neg_a;
                        sign_b  <= neg_b;
                        op_div  <= (md_func == FUNC_DIV);
                        cnt     <= 5'd0;
                        work_hi <= 32'd0;
                        work_lo <= (md_func == FUNC_DIV) ? abs_a : abs_b;
                    end else if (move_to) begin
                        if (md_func == FUNC_MTHI) hi_out <= src_a;
                        else                      lo_out <= src_a;
                    end
                end
                MUL: begin
                    if (!flush) begin
                        {work_hi, work_lo} <= mul_next;
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV: begin
                    if (!flush) begin
                        {work_hi, work_lo} <= div_next;
                        cnt <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi_out <= fix_hi;
                        lo_out <= fix_lo;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed corner cases plus randomized
// operations compared against an arithmetic HI/LO reference model.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic [31:0] hi_out, lo_out;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    md_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_func (md_func),
        .md_sign (md_sign),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} straight from integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] f, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (f == 3'b001) begin
            if (sgn) return longint'($signed(a)) * longint'($signed(b));
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input logic exp_busy, input logic exp_done);
        check_val({tag, "_busy"}, {63'd0, busy}, {63'd0, exp_busy});
        check_val({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
        check_val({tag, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
        check_val({tag, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
    endtask

    // Issues a MULT/DIV, pokes ignored starts while busy, checks timing and result.
    task automatic run_muldiv(input string tag, input logic [2:0] f, input logic sgn,
                              input logic [31:0] a, input logic [31:0] b, input logic noise);
        logic [63:0] res;
        int n, early_done, held_bad;
        res = model(f, sgn, a, b);
        start = 1'b1; md_func = f; md_sign = sgn; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0; early_done = 0; held_bad = 0;
        while (busy && n < 40) begin
            n++;
            if (done) early_done++;
            if (hi_out !== exp_hi || lo_out !== exp_lo) held_bad++;
            if (noise) begin
                start   = ($urandom_range(0, 2) == 0);
                md_func = 3'($urandom_range(0, 7));
                md_sign = 1'($urandom);
                src_a   = $urandom;
                src_b   = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check_val({tag, "_early_done"}, 64'(early_done), 64'd0);
        check_val({tag, "_hold"}, 64'(held_bad), 64'd0);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        check_outputs({tag, "_end"}, 1'b0, 1'b1);
        @(negedge clk);
        check_val({tag, "_done_once"}, {63'd0, done}, 64'd0);
    endtask

    task automatic run_idle_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic with_flush);
        start = 1'b1; md_func = f; md_sign = 1'($urandom); src_a = a; src_b = $urandom;
        flush = with_flush;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (!with_flush && f == 3'b011) exp_hi = a;
        if (!with_flush && f == 3'b100) exp_lo = a;
        check_outputs(tag, 1'b0, 1'b0);
    endtask

    initial begin
        int n, dcount;
        logic [2:0] f;
        rst_n = 1'b0; start = 1'b0; md_func = 3'd0; md_sign = 1'b0;
        src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
        #12;
        check_outputs("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_muldiv("mul_7x6", 3'b001, 1'b0, 32'd7, 32'd6, 1'b0);
        run_muldiv("mul_s_m3x5", 3'b001, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_muldiv("mul_u_ffx2", 3'b001, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_muldiv("div_s_m7d2", 3'b010, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_muldiv("div_u_100d0", 3'b010, 1'b0, 32'd100, 32'd0, 1'b0);
        run_muldiv("div_s_neg_d0", 3'b010, 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_muldiv("div_s_ovf", 3'b010, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        run_idle_op("mtlo", 3'b100, 32'h1234_5678, 1'b0);
        run_idle_op("mthi", 3'b011, 32'hCAFE_F00D, 1'b0);
        run_idle_op("noop", 3'b111, 32'hDEAD_BEEF, 1'b0);
        run_idle_op("flush_mthi", 3'b011, 32'h0BAD_0BAD, 1'b1);
        run_idle_op("flush_mult", 3'b001, 32'd9, 1'b1);

        // MTHI while busy must be ignored
        start = 1'b1; md_func = 3'b001; md_sign = 1'b0; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        md_func = 3'b011; src_a = 32'h5555_AAAA;
        @(negedge clk);
        start = 1'b0;
        check_outputs("mthi_busy", 1'b1, 1'b0);
        while (busy && n < 40) begin n++; @(negedge clk); end
        exp_hi = 32'd0; exp_lo = 32'd12;
        check_outputs("mthi_busy_end", 1'b0, 1'b1);
        @(negedge clk);

        // flush at cycle 10 of a DIV
        start = 1'b1; md_func = 3'b010; md_sign = 1'b0; src_a = 32'd1000; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_outputs("flush_div", 1'b0, 1'b0);
        dcount = 0;
        repeat (5) begin @(negedge clk); if (done || busy) dcount++; end
        check_val("flush_quiet", 64'(dcount), 64'd0);
        run_muldiv("mul_after_flush", 3'b001, 1'b0, 32'd11, 32'd13, 1'b0);

        // reset at cycle 20 of a MULT
        run_idle_op("pre_rst_mthi", 3'b011, 32'h1111_2222, 1'b0);
        start = 1'b1; md_func = 3'b001; md_sign = 1'b1; src_a = 32'hFFFF_0001; src_b = 32'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check_outputs("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin @(negedge clk); if (done || busy) dcount++; end
        check_val("rst_no_done", 64'(dcount), 64'd0);
        check_outputs("rst_after", 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: run_muldiv("rnd_mul", 3'b001, 1'($urandom), pick_operand(), pick_operand(), 1'b1);
                4, 5, 6, 7: run_muldiv("rnd_div", 3'b010, 1'($urandom), pick_operand(), pick_operand(), 1'b1);
                default: begin
                    f = 3'($urandom_range(0, 7));
                    if (f == 3'b001 || f == 3'b010) f = 3'b011;
                    run_idle_op("rnd_idle", f, $urandom, 1'($urandom_range(0, 3) == 0));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: issue request from EX, sampled each rising edge.
REQ-004 SHALL have port md_func, input, 3: 3'b001 MULT, 3'b010 DIV, 3'b011 MTHI, 3'b100 MTLO; other codes are no-ops.
REQ-005 SHALL have port md_sign, input, 1: 1 = signed MULT/DIV, 0 = unsigned.
REQ-006 SHALL have port src_a, input, 32: multiplicand/dividend, or MTHI/MTLO data.
REQ-007 SHALL have port src_b, input, 32: multiplier/divisor.
REQ-008 SHALL have port flush, input, 1: aborts any in-flight MULT/DIV.
REQ-009 SHALL have port hi_out, output, 32: architectural HI register.
REQ-010 SHALL have port lo_out, output, 32: architectural LO register.
REQ-011 SHALL have port busy, output, 1: operation in flight; consumed by stall detection.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on MULT/DIV completion.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX; busy = (state != IDLE), registered-state decode.
REQ-014 In IDLE, start with MULT/DIV (flush=0) at edge E0 SHALL latch operand magnitudes (absolute values if md_sign, raw if not) plus both sign bits, clear a 5-bit iteration counter, and enter MUL/DIV.
REQ-015 MUL SHALL perform one shift-add step per cycle on the 64-bit unsigned product; DIV SHALL perform one restoring shift-subtract step per cycle (32-bit quotient, 32-bit remainder).
REQ-016 After the 32nd step (edge E32) the state SHALL move to FIX; at E33 HI/LO SHALL be written, the state SHALL return to IDLE, and done SHALL be 1 for exactly the cycle following E33.
REQ-017 Busy SHALL be 1 for exactly the 33 cycles following E0; latency is identical for every operand value.
REQ-018 FIX for signed MULT SHALL negate the 64-bit product when sign_a ^ sign_b; {HI,LO} = product.
REQ-019 FIX for signed DIV SHALL negate the quotient when sign_a ^ sign_b and the remainder when sign_a; HI = remainder, LO = quotient.
REQ-020 Divide by zero SHALL complete in 33 cycles with HI = src_a (as latched), LO = 32'hFFFFFFFF, regardless of md_sign.
REQ-021 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield LO = 32'h80000000, HI = 0 (natural wrap).
REQ-022 MTHI/MTLO with start in IDLE SHALL write HI/LO from src_a at that edge; busy and done SHALL stay 0.
REQ-023 Start while busy SHALL be ignored (no state, HI/LO or counter change).
REQ-024 HI/LO SHALL change only at E33 or on MTHI/MTLO; working registers SHALL be separate and never visible on hi_out/lo_out.
REQ-025 Flush in MUL/DIV/FIX SHALL return to IDLE at the next edge with HI/LO unchanged and no done pulse.
REQ-026 Flush and start in the same cycle SHALL ignore start, including MTHI/MTLO.
REQ-027 Flush in IDLE SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, working registers 0, hi_out = 0, lo_out = 0, busy = 0, done = 0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no done follows deassertion.

Verification
REQ-030 Unsigned MULT 7 x 6 -> busy high 33 cycles; after E33: HI = 0, LO = 42, done pulse once.
REQ-031 Signed MULT -3 x 5 -> HI = 32'hFFFFFFFF, LO = 32'hFFFFFFF1; unsigned 32'hFFFFFFFF x 2 -> HI = 1, LO = 32'hFFFFFFFE.
REQ-032 Signed DIV -7 / 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF; unsigned DIV 100 / 0 -> HI = 100, LO = 32'hFFFFFFFF.
REQ-033 MTLO 32'h12345678 in IDLE -> lo_out = 32'h12345678 the next cycle, busy stays 0; MTHI issued while busy -> hi_out unchanged.
REQ-034 Flush at cycle 10 of a DIV -> busy 0 the next cycle, HI/LO hold prior values, no done; a new MULT is then accepted normally.
REQ-035 rst_n pulsed low at cycle 20 of a MULT -> outputs 0 asynchronously, no done after release.
